// File: rtl/bcd_counter_4dig_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_counter_4dig_pkg
// Brief    : Shared BCD digit constants for the 4-digit counter.
// Revision : 1.0 - initial release
// ============================================================================
package bcd_counter_4dig_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned NUM_DIGITS = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX  = 4'd9;
  localparam logic [DIGIT_W-1:0] BCD_ZERO = 4'd0;

endpackage
`default_nettype wire

// File: rtl/bcd_counter_4dig_bcd_digit.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit
// Brief    : One decade; o_wrap flags that this step rolls the digit over.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit
  import bcd_counter_4dig_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clr,
  input  logic               i_inc,
`ifdef BCD_DOWN_COUNT_EN
  input  logic               i_dec,
`endif
  output logic [DIGIT_W-1:0] o_digit,
  output logic               o_wrap
);

  logic [DIGIT_W-1:0] r_digit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digit <= BCD_ZERO;
    end else if (i_clr) begin
      r_digit <= BCD_ZERO;
    end else if (i_inc) begin
      r_digit <= (r_digit == BCD_MAX) ? BCD_ZERO : r_digit + 4'd1;
`ifdef BCD_DOWN_COUNT_EN
    end else if (i_dec) begin
      r_digit <= (r_digit == BCD_ZERO) ? BCD_MAX : r_digit - 4'd1;
`endif
    end
  end

`ifdef BCD_DOWN_COUNT_EN
  assign o_wrap = (i_inc && (r_digit == BCD_MAX)) || (i_dec && (r_digit == BCD_ZERO));
`else
  assign o_wrap = i_inc && (r_digit == BCD_MAX);
`endif

  assign o_digit = r_digit;

endmodule
`default_nettype wire

// File: rtl/bcd_counter_4dig.sv
`default_nettype none
// ============================================================================
// Module   : bcd_counter_4dig
// Brief    : Prescaled 4-digit BCD counter with wrap carry pulse.
//            Define BCD_DOWN_COUNT_EN to add the up_dn port and down counting.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_counter_4dig
  import bcd_counter_4dig_pkg::*;
#(
  parameter int unsigned TICK_DIV = 32'd50000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
`ifdef BCD_DOWN_COUNT_EN
  input  logic               up_dn,
`endif
  output logic [DIGIT_W-1:0] units,
  output logic [DIGIT_W-1:0] tens,
  output logic [DIGIT_W-1:0] hundreds,
  output logic [DIGIT_W-1:0] thousands,
  output logic               carry
);

  // A 1-bit prescaler still works for TICK_DIV=1: terminal value is 0.
  localparam int unsigned        c_P_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_P_W-1:0]   c_P_LAST = c_P_W'(TICK_DIV - 1);

  logic [c_P_W-1:0]   r_p;
  logic               r_carry;
  logic               w_tick;
  logic [DIGIT_W-1:0] w_digit [NUM_DIGITS];

  assign w_tick = en && (r_p == c_P_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p <= '0;
    end else if (clr) begin
      r_p <= '0;
    end else if (en) begin
      r_p <= (r_p == c_P_LAST) ? '0 : r_p + c_P_W'(1);
    end
  end

  // Step ripples through all decades combinationally within the step edge.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    logic w_step;
    logic w_wrap;

    if (k == 0) begin : g_first
      assign w_step = w_tick;
    end else begin : g_next
      assign w_step = g_digit[k-1].w_wrap;
    end

    bcd_digit u_digit (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (clr),
`ifdef BCD_DOWN_COUNT_EN
      .i_inc   (w_step && up_dn),
      .i_dec   (w_step && !up_dn),
`else
      .i_inc   (w_step),
`endif
      .o_digit (w_digit[k]),
      .o_wrap  (w_wrap)
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry <= 1'b0;
    end else if (clr) begin
      r_carry <= 1'b0;
    end else begin
      r_carry <= g_digit[NUM_DIGITS-1].w_wrap;
    end
  end

  assign units     = w_digit[0];
  assign tens      = w_digit[1];
  assign hundreds  = w_digit[2];
  assign thousands = w_digit[3];
  assign carry     = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_bcd_counter_4dig.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_counter_4dig
// Brief    : Directed bench with a decimal reference model, TICK_DIV=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_counter_4dig;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       clr;
  logic       up_dn;
  logic [3:0] units, tens, hundreds, thousands;
  logic       carry;

  int checks = 0;
  int errors = 0;

  // Reference model: count value as a plain integer 0..9999
  int m_val   = 0;
  int m_p     = 0;
  bit m_carry = 1'b0;
  bit carry_seen = 1'b0;

  bcd_counter_4dig #(.TICK_DIV(TD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .clr       (clr),
`ifdef BCD_DOWN_COUNT_EN
    .up_dn     (up_dn),
`endif
    .units     (units),
    .tens      (tens),
    .hundreds  (hundreds),
    .thousands (thousands),
    .carry     (carry)
  );

  always #5 clk = ~clk;

  function automatic int dut_val();
    return int'(thousands) * 1000 + int'(hundreds) * 100 + int'(tens) * 10 + int'(units);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge rst_n) begin
    m_val = 0; m_p = 0; m_carry = 1'b0;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m_val = 0; m_p = 0; m_carry = 1'b0;
    end else if (clr) begin
      m_val = 0; m_p = 0; m_carry = 1'b0;
    end else begin
      m_carry = 1'b0;
      if (en) begin
        if (m_p == TD - 1) begin
          m_p = 0;
`ifdef BCD_DOWN_COUNT_EN
          if (!up_dn) begin
            m_carry = (m_val == 0);
            m_val = (m_val + 9999) % 10000;
          end else
`endif
          begin
            m_carry = (m_val == 9999);
            m_val = (m_val + 1) % 10000;
          end
        end else begin
          m_p = m_p + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("model_value", dut_val(), m_val);
    chk("model_carry", int'(carry), int'(m_carry));
    chk("digit_range", int'(units <= 9 && tens <= 9 && hundreds <= 9 && thousands <= 9), 1);
    if (carry) carry_seen = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; up_dn = 1'b1;
    #12;
    chk("reset_value", dut_val(), 0);
    chk("reset_carry", int'(carry), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    en    = 1'b1;

    // First step on the 4th enabled edge, 40 edges give 0010
    tick(3);
    chk("pre_first_step", dut_val(), 0);
    tick(1);
    chk("first_step", dut_val(), 1);
    tick(36);
    chk("after_40", dut_val(), 10);
    chk("no_carry_40", int'(carry_seen), 0);

    // Count up to 9998, then wrap
    tick(TD * 9988);
    chk("preload_9998", dut_val(), 9998);
    tick(TD);
    chk("at_9999", dut_val(), 9999);
    chk("no_carry_9999", int'(carry), 0);
    tick(TD);
    chk("wrap_0000", dut_val(), 0);
    chk("wrap_carry", int'(carry), 1);
    tick(1);
    chk("carry_one_cycle", int'(carry), 0);

    // Reach 0019 with prescaler at 2, then freeze
    tick(77);
    chk("at_0019", dut_val(), 19);
    en = 1'b0;
    tick(10);
    chk("frozen_0019", dut_val(), 19);
    en = 1'b1;
    tick(1);
    chk("resume_1", dut_val(), 19);
    tick(1);
    chk("resume_2", dut_val(), 20);

    // clr on a step edge from 0009
    clr = 1'b1; tick(1); clr = 1'b0;
    tick(36);
    chk("at_0009", dut_val(), 9);
    tick(3);
    clr = 1'b1; tick(1); clr = 1'b0;
    chk("clr_over_step", dut_val(), 0);
    chk("clr_carry", int'(carry), 0);
    tick(3);
    chk("clr_restart_3", dut_val(), 0);
    tick(1);
    chk("clr_restart_4", dut_val(), 1);

    // Asynchronous reset between edges at 0537
    tick(TD * 536);
    chk("at_0537", dut_val(), 537);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset", dut_val(), 0);
    chk("async_reset_carry", int'(carry), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    tick(3);
    chk("post_reset_3", dut_val(), 0);
    tick(1);
    chk("post_reset_4", dut_val(), 1);

`ifdef BCD_DOWN_COUNT_EN
    clr = 1'b1; tick(1); clr = 1'b0;
    up_dn = 1'b0;
    tick(TD);
    chk("down_wrap", dut_val(), 9999);
    chk("down_wrap_carry", int'(carry), 1);
    tick(TD);
    chk("down_9998", dut_val(), 9998);
    tick(TD);
    chk("down_9997", dut_val(), 9997);
    up_dn = 1'b1;
    tick(TD);
    chk("up_9998", dut_val(), 9998);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
